demux32_1to4_buf: RTL and testbench
===================================

DEMUX32_1TO4_BUF -- requirements
Module: demux32_1to4_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter CNTW, default 16, width of the per-channel transfer counters.
REQ-003 SHALL have port Clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream word present.
REQ-006 SHALL have port in_ready  output  1  block accepts the upstream word this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  upstream word.
REQ-008 SHALL have port in_sel  input  2  destination channel, 0..3.
REQ-009 SHALL have port out_valid  output  4  bit k set means channel k holds a word.
REQ-010 SHALL have port out_ready  input  4  bit k set means the channel k consumer takes its word.
REQ-011 SHALL have ports out_data0, out_data1, out_data2, out_data3  output  WIDTH  each port is the held word of its channel.
REQ-012 SHALL have ports cnt0, cnt1, cnt2, cnt3  output  CNTW  each is the count of completed transfers out of its channel.

Function
REQ-013 SHALL hold exactly one single-entry register per channel, storing a data word and a valid flag, and SHALL have no other storage.
REQ-014 SHALL complete an upstream transfer in any cycle where in_valid and in_ready are both 1.
REQ-015 SHALL complete a channel k transfer in any cycle where out_valid[k] and out_ready[k] are both 1.
REQ-016 SHALL drive in_ready combinationally as !out_valid[in_sel] || out_ready[in_sel].
- A full channel that drains this cycle accepts a new word in the same cycle.
- in_ready depends only on the selected channel, so a full channel never blocks words bound for other channels.
REQ-017 SHALL, on an upstream transfer to channel k, load in_data into channel k's register and set out_valid[k] on the next edge, giving 1-cycle latency.
REQ-018 SHALL clear out_valid[k] on the next edge after a channel k transfer, unless a new word for channel k is accepted in the same cycle.
REQ-019 SHALL, when channel k drains and is reloaded in the same cycle, keep out_valid[k] at 1 and replace out_data_k with the new word on the next edge, so throughput is one word per cycle.
REQ-020 SHALL hold out_data_k and out_valid[k] stable while out_valid[k] is 1 and out_ready[k] is 0.
REQ-021 SHALL ignore in_sel and in_data whenever in_valid is 0; out_ready[k] while out_valid[k] is 0 SHALL have no effect.
REQ-022 SHALL allow up to four channels to drain in the same cycle, independently of each other.
REQ-023 SHALL increment cnt_k by 1 on each channel k transfer, wrap modulo 2^CNTW from all-ones to 0, and never saturate.
REQ-024 SHALL leave out_data_k at its last value after channel k drains; its value is don't-care while out_valid[k] is 0.
REQ-025 SHALL contain no combinational path from in_data to any output.

Reset
REQ-026 SHALL, while Reset is 1, immediately and asynchronously force out_valid=4'b0000, all out_data_k=0, and all cnt_k=0.
REQ-027 SHALL drive in_ready as 1 while Reset is 1, and SHALL accept no word during reset.
REQ-028 SHALL, on Reset asserted mid-operation, discard all held words without completing their transfers and leave the counters at 0.
REQ-029 SHALL accept a word on the first rising edge after Reset deasserts.

Verification
REQ-030 Bench SHALL cover basic routing: one word each with in_data=0xA5A5A5A5 and in_sel=2, out_ready=0 -> next cycle out_valid=4'b0100, out_data2=0xA5A5A5A5, cnt2=0; then out_ready[2]=1 for one cycle -> out_valid=0 and cnt2=1.
REQ-031 Bench SHALL cover backpressure and isolation: channel 1 full with out_ready[1]=0, in_sel=1 -> in_ready=0 and out_data1 unchanged; switch to in_sel=3 -> in_ready=1 and word lands on channel 3.
REQ-032 Bench SHALL cover a simultaneous drain and refill: channel 0 holds 0x11, out_ready[0]=1, in_sel=0, in_data=0x22 -> in_ready=1; next cycle out_valid[0]=1, out_data0=0x22, cnt0=1.
REQ-033 Bench SHALL cover streaming: 8 back-to-back words to channel 3 with out_ready[3]=1 throughout -> in_ready held at 1; words appear in order with 1-cycle latency; cnt3=8.
REQ-034 Bench SHALL cover counter wrap: 2^CNTW transfers on channel 0 (CNTW=4 in the test build) -> cnt0 goes 15 to 0.
REQ-035 Bench SHALL cover reset mid-operation: all four channels full with nonzero counters; assert Reset between clock edges -> out_valid=0, all counters 0, in_ready=1 before the next edge.

Source files
------------

// File: rtl/demux32_1to4_buf.sv
// One-to-four demultiplexer with a single-entry skid register per channel
// and a free-running transfer counter on each output channel.
module demux32_1to4_buf #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [CNTW-1:0]  cnt0,
  output logic [CNTW-1:0]  cnt1,
  output logic [CNTW-1:0]  cnt2,
  output logic [CNTW-1:0]  cnt3
);

  localparam int unsigned NCH = 4;

  logic [NCH-1:0]   valid_q, valid_d;
  logic [WIDTH-1:0] data_q [NCH];
  logic [WIDTH-1:0] data_d [NCH];
  logic [CNTW-1:0]  cnt_q  [NCH];
  logic [CNTW-1:0]  cnt_d  [NCH];
  logic [NCH-1:0]   drain;
  logic [NCH-1:0]   load;

  // Readiness looks only at the selected channel; a draining channel can refill.
  assign in_ready = !valid_q[in_sel] || out_ready[in_sel];

  always_comb begin
    drain   = valid_q & out_ready;
    load    = (in_valid && in_ready) ? (NCH'(1) << in_sel) : '0;
    valid_d = (valid_q & ~drain) | load;
    for (int k = 0; k < NCH; k++) begin
      data_d[k] = load[k] ? in_data : data_q[k];
      cnt_d[k]  = cnt_q[k] + CNTW'(drain[k]);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      valid_q <= '0;
      for (int k = 0; k < NCH; k++) begin
        data_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < NCH; k++) begin
        data_q[k] <= data_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];
  assign cnt0      = cnt_q[0];
  assign cnt1      = cnt_q[1];
  assign cnt2      = cnt_q[2];
  assign cnt3      = cnt_q[3];

endmodule

// File: tb/tb_demux32_1to4_buf.sv
// Self-checking bench for demux32_1to4_buf: directed table, corner sequences,
// and randomized traffic against a channel-occupancy reference model.
module tb_demux32_1to4_buf;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 4;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [1:0]    in_sel = '0;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready = '0;
  logic [W-1:0]  out_data0, out_data1, out_data2, out_data3;
  logic [CW-1:0] cnt0, cnt1, cnt2, cnt3;

  logic [W-1:0]  od [4];
  logic [CW-1:0] oc [4];
  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;
  assign oc[0] = cnt0;
  assign oc[1] = cnt1;
  assign oc[2] = cnt2;
  assign oc[3] = cnt3;

  int checks = 0;
  int errors = 0;

  demux32_1to4_buf #(.WIDTH(W), .CNTW(CW)) dut (
    .Clk(Clk), .Reset(Reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1),
    .out_data2(out_data2), .out_data3(out_data3),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        iv;
    logic [1:0]  sel;
    logic [31:0] data;
    logic [3:0]  ordy;
    logic        exp_irdy;
    logic [3:0]  exp_ov;
    int          ch;
    logic [31:0] exp_data;
    logic [3:0]  exp_cnt;
  } vec_t;

  vec_t tbl [9];

  // Reference model state: per-channel occupancy, held word and transfer count.
  logic        mv [4];
  logic [31:0] md [4];
  int          mc [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [1:0] sel, input logic [31:0] d,
                       input logic [3:0] ordy);
    in_valid  = iv;
    in_sel    = sel;
    in_data   = d;
    out_ready = ordy;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic reset_dut();
    drive(1'b0, 2'd0, 32'h0, 4'b0000);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 2'd2, 32'hA5A5A5A5, 4'b0000, 1'b1, 4'b0100, 2, 32'hA5A5A5A5, 4'd0};
    tbl[1] = '{1'b0, 2'd0, 32'h0,        4'b0100, 1'b1, 4'b0000, 2, 32'hA5A5A5A5, 4'd1};
    tbl[2] = '{1'b1, 2'd1, 32'h11110001, 4'b0000, 1'b1, 4'b0010, 1, 32'h11110001, 4'd0};
    tbl[3] = '{1'b1, 2'd1, 32'hDEADBEEF, 4'b0000, 1'b0, 4'b0010, 1, 32'h11110001, 4'd0};
    tbl[4] = '{1'b1, 2'd3, 32'h33333333, 4'b0000, 1'b1, 4'b1010, 3, 32'h33333333, 4'd0};
    tbl[5] = '{1'b1, 2'd0, 32'h00000011, 4'b0000, 1'b1, 4'b1011, 0, 32'h00000011, 4'd0};
    tbl[6] = '{1'b1, 2'd0, 32'h00000022, 4'b0001, 1'b1, 4'b1011, 0, 32'h00000022, 4'd1};
    tbl[7] = '{1'b0, 2'd1, 32'hFFFFFFFF, 4'b1111, 1'b1, 4'b0000, 1, 32'h11110001, 4'd1};
    tbl[8] = '{1'b0, 2'd3, 32'h0,        4'b1111, 1'b1, 4'b0000, 3, 32'h33333333, 4'd1};

    // Reset state, with traffic offered that must be ignored.
    drive(1'b1, 2'd1, 32'h12345678, 4'b1111);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_data%0d", k), 64'(od[k]), 64'h0);
      chk($sformatf("rst_cnt%0d", k), 64'(oc[k]), 64'h0);
    end
    step();
    chk("rst_hold_valid", 64'(out_valid), 64'h0);
    reset_dut();

    // Directed table: routing, backpressure isolation, drain+refill, multi-drain.
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].iv, tbl[i].sel, tbl[i].data, tbl[i].ordy);
      #1;
      chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].exp_irdy));
      step();
      chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].exp_ov));
      chk($sformatf("tbl%0d_data", i), 64'(od[tbl[i].ch]), 64'(tbl[i].exp_data));
      chk($sformatf("tbl%0d_cnt", i), 64'(oc[tbl[i].ch]), 64'(tbl[i].exp_cnt));
    end

    // Streaming: eight back-to-back words through channel 3.
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'd3, 32'hC0DE0000 + 32'(i), 4'b1000);
      #1;
      chk($sformatf("stream%0d_in_ready", i), 64'(in_ready), 64'h1);
      step();
      chk($sformatf("stream%0d_valid3", i), 64'(out_valid), 64'h8);
      chk($sformatf("stream%0d_data3", i), 64'(out_data3), 64'(32'hC0DE0000 + 32'(i)));
      chk($sformatf("stream%0d_cnt3", i), 64'(cnt3), 64'(i));
    end
    drive(1'b0, 2'd0, 32'h0, 4'b1000);
    step();
    chk("stream_end_valid", 64'(out_valid), 64'h0);
    chk("stream_end_cnt3", 64'(cnt3), 64'd8);

    // Counter wrap on channel 0: sixteen transfers bring the 4-bit count 15 -> 0.
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 2'd0, 32'(i), 4'b0001);
      step();
      chk($sformatf("wrap%0d_cnt0", i), 64'(cnt0), 64'(i));
    end
    drive(1'b0, 2'd0, 32'h0, 4'b0001);
    step();
    chk("wrap_cnt0_zero", 64'(cnt0), 64'h0);
    chk("wrap_valid", 64'(out_valid), 64'h0);

    // Reset mid-operation with all channels full and counters at 1.
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'(k), 32'hAA00 + 32'(k), 4'b0000);
      step();
    end
    drive(1'b0, 2'd0, 32'h0, 4'b1111);
    step();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'(k), 32'hBB00 + 32'(k), 4'b0000);
      step();
    end
    chk("pre_rst_valid", 64'(out_valid), 64'hF);
    chk("pre_rst_cnt1", 64'(cnt1), 64'h1);
    drive(1'b1, 2'd0, 32'h5555, 4'b0000);
    #1;
    chk("pre_rst_in_ready", 64'(in_ready), 64'h0);
    #2;
    Reset = 1'b1;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'h0);
    chk("midrst_in_ready", 64'(in_ready), 64'h1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("midrst_cnt%0d", k), 64'(oc[k]), 64'h0);
      chk($sformatf("midrst_data%0d", k), 64'(od[k]), 64'h0);
    end
    step();
    chk("midrst_no_accept", 64'(out_valid), 64'h0);
    Reset = 1'b0;
    drive(1'b1, 2'd2, 32'h0000BEEF, 4'b0000);
    step();
    chk("post_rst_valid", 64'(out_valid), 64'h4);
    chk("post_rst_data2", 64'(out_data2), 64'h0000BEEF);

    // Randomized traffic against the reference model.
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      mv[k] = 1'b0;
      md[k] = '0;
      mc[k] = 0;
    end
    for (int n = 0; n < 400; n++) begin
      logic        r_iv;
      logic [1:0]  r_sel;
      logic [31:0] r_d;
      logic [3:0]  r_ordy;
      logic        e_rdy;
      logic [3:0]  e_ov;
      r_iv   = 1'($urandom_range(0, 3) != 0);
      r_sel  = 2'($urandom_range(0, 3));
      r_d    = $urandom;
      r_ordy = 4'($urandom_range(0, 15));
      drive(r_iv, r_sel, r_d, r_ordy);
      e_rdy = !mv[r_sel] || r_ordy[r_sel];
      #1;
      chk($sformatf("rnd%0d_in_ready", n), 64'(in_ready), 64'(e_rdy));
      for (int k = 0; k < 4; k++) begin
        if (mv[k] && r_ordy[k]) begin
          mc[k]++;
          mv[k] = 1'b0;
        end
      end
      if (r_iv && e_rdy) begin
        mv[r_sel] = 1'b1;
        md[r_sel] = r_d;
      end
      step();
      e_ov = {mv[3], mv[2], mv[1], mv[0]};
      chk($sformatf("rnd%0d_out_valid", n), 64'(out_valid), 64'(e_ov));
      for (int k = 0; k < 4; k++) begin
        if (mv[k]) chk($sformatf("rnd%0d_data%0d", n, k), 64'(od[k]), 64'(md[k]));
        chk($sformatf("rnd%0d_cnt%0d", n, k), 64'(oc[k]), 64'(mc[k] % 16));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
